axi_rd_rr_arbiter: RTL and testbench
====================================

# axi_rd_rr_arbiter

Round-robin arbiter that shares one AXI4 read master port between NUM_REQ DMA read requesters. It accepts AR requests from the requesters and issues them through a registered AR stage, tagging each with the requester index as ARID. R beats are routed back by RID, and accepted-but-incomplete bursts are tracked per requester. It sits between the DMA read engines and the master port that feeds the passthrough/slave VIP chain in the example design.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_W, 32: address width.
- DATA_W, 32: read data width.
- ID_W, 2: ARID/RID width; must be ≥ $clog2(NUM_REQ).
- MAX_OUTST, 4: per-requester outstanding burst limit, 1..15.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- s_arvalid  in  NUM_REQ  per-requester AR valid.
- s_arready  out  NUM_REQ  per-requester AR ready, one-hot or zero.
- s_araddr  in  NUM_REQ*ADDR_W  packed; requester i at [i*ADDR_W +: ADDR_W].
- s_arlen  in  NUM_REQ*8  packed burst lengths.
- s_rvalid  out  NUM_REQ  routed R valid.
- s_rready  in  NUM_REQ  per-requester R ready.
- s_rdata  out  DATA_W  broadcast from m_rdata.
- s_rresp  out  2  broadcast from m_rresp.
- s_rlast  out  1  broadcast from m_rlast.
- m_arvalid  out  1  downstream AR valid, registered.
- m_arready  in  1  downstream AR ready.
- m_araddr  out  ADDR_W  registered.
- m_arlen  out  8  registered.
- m_arid  out  ID_W  granted requester index.
- m_rvalid, m_rdata, m_rresp, m_rlast, m_rid  in  1/DATA_W/2/1/ID_W  downstream R channel.
- m_rready  out  1  downstream R ready.
- rid_err  out  1  sticky flag: an R beat arrived with m_rid ≥ NUM_REQ.

## Operation
- FSM with two states, IDLE and ISSUE.
- IDLE: requester i is eligible when s_arvalid[i] is high and, with the limit feature enabled, outst[i] < MAX_OUTST. The round-robin pick starts at last_grant+1 mod NUM_REQ.
  - When a requester is picked: s_arready[pick] = 1 in the same cycle (combinational). m_araddr, m_arlen and m_arid = pick are captured. outst[pick] increments. The FSM goes to ISSUE.
- ISSUE: m_arvalid = 1, with address, length and ID held stable. All s_arready are 0.
  - On m_arready: last_grant ← m_arid and the FSM returns to IDLE.
- R routing, all combinational:
  - s_rvalid[i] = m_rvalid && m_rid == i.
  - m_rready = s_rready[m_rid].
  - If m_rid ≥ NUM_REQ: m_rready = 1 and the beat is dropped. rid_err is set on the beat's valid cycle and stays set until reset.
- Outstanding counters: outst[i] decrements on an R handshake with m_rlast and m_rid == i.
  - Simultaneous increment and decrement on the same i leaves outst[i] unchanged.
  - A decrement at 0 saturates at 0.

## Timing
- Reset values: state IDLE, m_arvalid 0, m_araddr 0, m_arlen 0, m_arid 0, last_grant NUM_REQ-1 (so requester 0 wins first), every outst 0, rid_err 0.
- While reset is high, s_arready is forced to 0. s_rvalid and m_rready follow the combinational routing.
- Latency:
  - s_arvalid rising in cycle T with the FSM in IDLE gives s_arready in T and m_arvalid in T+1.
  - Minimum AR issue interval is 2 cycles (IDLE→ISSUE→IDLE).
- The AXI stability rule applies: once m_arvalid is high, it and the AR payload do not change until m_arready.
- R path adds 0 cycles of latency. There are no combinational paths from s_arvalid to m_arvalid.
- Reset asserted mid-ISSUE: m_arvalid drops in the cycle after reset is sampled, and the captured request is discarded.

## Configuration
- Macro `AXI_ARB_OUTST_LIMIT_EN`.
- Defined: outstanding counters gate eligibility as described above. A requester at MAX_OUTST is skipped until one of its bursts completes.
- Undefined: outstanding counters and the gating logic are not built, and every valid requester is eligible. MAX_OUTST is ignored.

## Structure
- Package axi_arb_pkg holds:
  - the axi_resp_t enum (OKAY, EXOKAY, SLVERR, DECERR);
  - the state_t enum {IDLE, ISSUE};
  - the constant AXI_LEN_W = 8;
  - the function that computes outstanding-counter width, $clog2(MAX_OUTST+1).
- One sub-module, axi_arb_rr_pick: a combinational round-robin picker with inputs req[NUM_REQ] and last[$clog2(NUM_REQ)], and outputs valid and idx.

## Test plan
- All 4 requesters hold s_arvalid with addresses 0x1000/0x2000/0x3000/0x4000 and m_arready tied 1 → m_arid issue order 0,1,2,3,0; one grant every 2 cycles.
- Requester 2 alone, m_arready held low for 5 cycles → m_arvalid, m_araddr and m_arid stay constant for 5 cycles; s_arready[2] pulses exactly once.
- `AXI_ARB_OUTST_LIMIT_EN` defined, MAX_OUTST=2, no R beats returned → requester 1 is granted twice, then skipped. One R beat with rlast and rid=1 → requester 1 is granted again next IDLE.
- R beats with rid=3, arlen=3 → s_rvalid[3] high for 4 beats. Deasserting s_rready[3] stalls m_rready, and the other s_rvalid bits stay 0.
- Bench built with NUM_REQ=3 drives m_rid=3 → m_rready=1, no s_rvalid bit is set, and rid_err stays 1 until reset.
- Reset asserted during ISSUE → m_arvalid is 0 the next cycle, outst is cleared, and requester 0 wins the first grant after reset.

Source files
------------

// File: rtl/axi_rd_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin AXI read arbiter.
// Optional feature macro: AXI_ARB_OUTST_LIMIT_EN (per-requester outstanding limit).
package axi_arb_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam int AXI_LEN_W = 8;

  // Counter must hold 0..max_outst inclusive.
  function automatic int outst_cnt_w(input int max_outst);
    return $clog2(max_outst + 1);
  endfunction

endpackage

// File: rtl/axi_rd_rr_arbiter_if.sv
// Bundle of requester-side and master-side AR/R signals around the arbiter.
// master: the arbiter's view; slave: the surrounding environment's view.
interface axi_rd_rr_arbiter_if
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]           s_arvalid;
  logic [NUM_REQ-1:0]           s_arready;
  logic [NUM_REQ*ADDR_W-1:0]    s_araddr;
  logic [NUM_REQ*AXI_LEN_W-1:0] s_arlen;
  logic [NUM_REQ-1:0]           s_rvalid;
  logic [NUM_REQ-1:0]           s_rready;
  logic [DATA_W-1:0]            s_rdata;
  axi_resp_t                    s_rresp;
  logic                         s_rlast;

  logic                         m_arvalid;
  logic                         m_arready;
  logic [ADDR_W-1:0]            m_araddr;
  logic [AXI_LEN_W-1:0]         m_arlen;
  logic [ID_W-1:0]              m_arid;
  logic                         m_rvalid;
  logic [DATA_W-1:0]            m_rdata;
  axi_resp_t                    m_rresp;
  logic                         m_rlast;
  logic [ID_W-1:0]              m_rid;
  logic                         m_rready;

  modport master (
    input  s_arvalid, s_araddr, s_arlen, s_rready,
    input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
    output m_arvalid, m_araddr, m_arlen, m_arid, m_rready
  );

  modport slave (
    output s_arvalid, s_araddr, s_arlen, s_rready,
    output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
    input  m_arvalid, m_araddr, m_arlen, m_arid, m_rready
  );
endinterface

// File: rtl/axi_rd_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module axi_arb_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               valid,
  output logic [SEL_W-1:0]   idx
);
  int cand_s;

  // Scan farthest-first so the candidate nearest to last+1 overwrites the others.
  always_comb begin
    valid  = 1'b0;
    idx    = {SEL_W{1'b0}};
    cand_s = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_s = (int'(last) + k) % NUM_REQ;
      valid  = valid | req[cand_s];
      idx    = req[cand_s] ? SEL_W'(cand_s) : idx;
    end
  end
endmodule

// File: rtl/axi_rd_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master among NUM_REQ requesters.
// Optional macro AXI_ARB_OUTST_LIMIT_EN gates eligibility by outstanding bursts.
module axi_rd_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                clock,
  input  logic                reset,
  axi_rd_rr_arbiter_if.master bus,
  output logic                rid_err
);
  localparam int SEL_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W < SEL_W || MAX_OUTST < 1 || MAX_OUTST > 15 ||
      (DATA_W % 8) != 0) begin : g_cfg_err
    $error("axi_rd_rr_arbiter: unsupported parameter set");
  end

  state_t               state_r, state_s;
  logic [SEL_W-1:0]     last_grant_r, pick_idx_s;
  logic                 pick_valid_s;
  logic [NUM_REQ-1:0]   eligible_s, grant_s, rvalid_s;
  logic [ADDR_W-1:0]    araddr_r;
  logic [AXI_LEN_W-1:0] arlen_r;
  logic [ID_W-1:0]      arid_r;
  logic                 rid_ok_s, rready_s, m_rready_s, rid_err_r;

  axi_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (eligible_s),
    .last  (last_grant_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Next state and the combinational one-hot grant back to the requester.
  always_comb begin
    state_s = state_r;
    grant_s = {NUM_REQ{1'b0}};
    case (state_r)
      IDLE: begin
        if (pick_valid_s && !reset) begin
          grant_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (bus.m_arready) begin
          state_s = IDLE;
        end else begin
          state_s = ISSUE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, captured AR payload and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      araddr_r     <= {ADDR_W{1'b0}};
      arlen_r      <= {AXI_LEN_W{1'b0}};
      arid_r       <= {ID_W{1'b0}};
      last_grant_r <= SEL_W'(NUM_REQ - 1);
    end else begin
      state_r <= state_s;
      if (state_r == IDLE && state_s == ISSUE) begin
        araddr_r <= bus.s_araddr[pick_idx_s*ADDR_W +: ADDR_W];
        arlen_r  <= bus.s_arlen[pick_idx_s*AXI_LEN_W +: AXI_LEN_W];
        arid_r   <= ID_W'(pick_idx_s);
      end else if (state_r == ISSUE && bus.m_arready) begin
        last_grant_r <= SEL_W'(arid_r);
      end
    end
  end

  assign bus.s_arready = grant_s;
  assign bus.m_arvalid = (state_r == ISSUE);
  assign bus.m_araddr  = araddr_r;
  assign bus.m_arlen   = arlen_r;
  assign bus.m_arid    = arid_r;

  // R routing by RID; beats with an out-of-range RID are drained.
  always_comb begin
    rid_ok_s = 1'b0;
    rready_s = 1'b0;
    rvalid_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      rvalid_s[i] = bus.m_rvalid && (bus.m_rid == ID_W'(i));
      rid_ok_s    = rid_ok_s | (bus.m_rid == ID_W'(i));
      rready_s    = rready_s | ((bus.m_rid == ID_W'(i)) & bus.s_rready[i]);
    end
    m_rready_s = rready_s | ~rid_ok_s;
  end

  assign bus.s_rvalid = rvalid_s;
  assign bus.m_rready = m_rready_s;
  assign bus.s_rdata  = bus.m_rdata;
  assign bus.s_rresp  = bus.m_rresp;
  assign bus.s_rlast  = bus.m_rlast;

  // Sticky flag for beats carrying an unknown RID.
  always_ff @(posedge clock) begin
    if (reset) begin
      rid_err_r <= 1'b0;
    end else if (bus.m_rvalid && !rid_ok_s) begin
      rid_err_r <= 1'b1;
    end
  end

  assign rid_err = rid_err_r;

`ifdef AXI_ARB_OUTST_LIMIT_EN
  localparam int CNT_W = outst_cnt_w(MAX_OUTST);

  logic [CNT_W-1:0]   outst_r [NUM_REQ];
  logic [NUM_REQ-1:0] rdone_s;

  // Burst completion per requester and limit-gated eligibility.
  always_comb begin
    rdone_s    = {NUM_REQ{1'b0}};
    eligible_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      rdone_s[i]    = bus.m_rvalid && m_rready_s && bus.m_rlast && (bus.m_rid == ID_W'(i));
      eligible_s[i] = bus.s_arvalid[i] && (outst_r[i] < CNT_W'(MAX_OUTST));
    end
  end

  // Outstanding-burst counters; grant and completion together cancel out.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset) begin
        outst_r[i] <= {CNT_W{1'b0}};
      end else begin
        case ({grant_s[i], rdone_s[i]})
          2'b10:   outst_r[i] <= outst_r[i] + CNT_W'(1);
          2'b01:   outst_r[i] <= (outst_r[i] == {CNT_W{1'b0}}) ? outst_r[i] : outst_r[i] - CNT_W'(1);
          default: outst_r[i] <= outst_r[i];
        endcase
      end
    end
  end
`else
  assign eligible_s = bus.s_arvalid;
`endif

endmodule

// File: tb/tb_axi_rd_rr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_axi_rd_rr_arbiter;
  import axi_arb_pkg::*;

  localparam int N    = 4;
  localparam int MAXO = 2;
`ifdef AXI_ARB_OUTST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rid_err4, rid_err3;
  int   total = 0;
  int   passed = 0;

  axi_rd_rr_arbiter_if #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .ID_W(2)) b4 ();
  axi_rd_rr_arbiter_if #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .ID_W(2)) b3 ();

  axi_rd_rr_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .ID_W(2), .MAX_OUTST(MAXO)) dut4 (
    .clock(clock), .reset(reset), .bus(b4), .rid_err(rid_err4));
  axi_rd_rr_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .ID_W(2), .MAX_OUTST(MAXO)) dut3 (
    .clock(clock), .reset(reset), .bus(b3), .rid_err(rid_err3));

  always #5 clock = ~clock;

  // Behavioural model of the 4-requester instance
  int          mdl_last = N - 1;
  bit          mdl_busy = 1'b0;
  int          mdl_id = 0;
  logic [31:0] mdl_addr = 32'h0;
  logic [7:0]  mdl_len = 8'h0;
  int          mdl_outst [N] = '{0, 0, 0, 0};
  bit          mdl_err = 1'b0;
  int          tick_grant = -1;

  function automatic int mdl_pick();
    if (reset || mdl_busy) return -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (mdl_last + k) % N;
      if (b4.s_arvalid[c] && (!LIMIT || mdl_outst[c] < MAXO)) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_arready();
    int p;
    p = mdl_pick();
    if (p < 0) return 4'b0000;
    return 4'b0001 << p;
  endfunction

  function automatic logic exp_rready();
    return b4.s_rready[b4.m_rid];
  endfunction

  function automatic logic [3:0] exp_rvalid();
    return b4.m_rvalid ? (4'b0001 << b4.m_rid) : 4'b0000;
  endfunction

  task automatic tick();
    int p, rid;
    bit rdone, arr, rs, rv;
    logic [31:0] a;
    logic [7:0] l;
    p = mdl_pick();
    rid = int'(b4.m_rid);
    rv = b4.m_rvalid;
    rdone = b4.m_rvalid && exp_rready() && b4.m_rlast;
    arr = b4.m_arready;
    rs = reset;
    a = (p >= 0) ? b4.s_araddr[p*32 +: 32] : 32'h0;
    l = (p >= 0) ? b4.s_arlen[p*8 +: 8] : 8'h0;
    @(posedge clock);
    tick_grant = p;
    if (rs) begin
      mdl_last = N - 1; mdl_busy = 1'b0; mdl_id = 0; mdl_addr = 32'h0; mdl_len = 8'h0;
      mdl_err = 1'b0; tick_grant = -1;
      for (int i = 0; i < N; i++) mdl_outst[i] = 0;
    end else begin
      if (mdl_busy && arr) begin
        mdl_last = mdl_id; mdl_busy = 1'b0;
      end else if (p >= 0) begin
        mdl_busy = 1'b1; mdl_id = p; mdl_addr = a; mdl_len = l;
      end
      if (rv && rid >= N) mdl_err = 1'b1;
      for (int i = 0; i < N; i++) begin
        bit inc, dec;
        inc = (p == i);
        dec = rdone && (rid == i);
        if (inc && !dec) mdl_outst[i]++;
        else if (dec && !inc && mdl_outst[i] > 0) mdl_outst[i]--;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    b4.s_arvalid = '0; b4.s_araddr = '0; b4.s_arlen = '0; b4.s_rready = '0; b4.m_arready = 1'b0;
    b4.m_rvalid = 1'b0; b4.m_rdata = '0; b4.m_rresp = OKAY; b4.m_rlast = 1'b0; b4.m_rid = '0;
    b3.s_arvalid = '0; b3.s_araddr = '0; b3.s_arlen = '0; b3.s_rready = '0; b3.m_arready = 1'b0;
    b3.m_rvalid = 1'b0; b3.m_rdata = '0; b3.m_rresp = OKAY; b3.m_rlast = 1'b0; b3.m_rid = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    b4.s_arvalid = 4'hF;
    tick(); tick();
    total++; if (b4.s_arready !== 4'b0000) $display("FAIL reset_arready: got %b expected 0000", b4.s_arready); else passed++;
    total++; if (b4.m_arvalid !== 1'b0) $display("FAIL reset_arvalid: got %b expected 0", b4.m_arvalid); else passed++;
    total++; if (b4.m_araddr !== 32'h0) $display("FAIL reset_araddr: got %h expected 0", b4.m_araddr); else passed++;
    total++; if (b4.m_arlen !== 8'h0) $display("FAIL reset_arlen: got %h expected 0", b4.m_arlen); else passed++;
    total++; if (b4.m_arid !== 2'd0) $display("FAIL reset_arid: got %0d expected 0", b4.m_arid); else passed++;
    total++; if ({rid_err4, rid_err3} !== 2'b00) $display("FAIL reset_rid_err: got %b expected 00", {rid_err4, rid_err3}); else passed++;
    reset = 1'b0;
    b4.s_arvalid = 4'h0;
  endtask

  task automatic test_rr_order();
    int order[$];
    int when[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) begin
      b4.s_araddr[i*32 +: 32] = 32'h1000 * (i + 1);
      b4.s_arlen[i*8 +: 8] = 8'(i);
    end
    b4.s_arvalid = 4'hF;
    b4.m_arready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      total++; if (b4.s_arready !== exp_arready()) $display("FAIL rr_arready[%0d]: got %b expected %b", c, b4.s_arready, exp_arready()); else passed++;
      tick();
      if (tick_grant >= 0) begin order.push_back(tick_grant); when.push_back(c); end
    end
    total++; if (order.size() != 5) $display("FAIL rr_grant_count: got %0d expected 5", order.size()); else passed++;
    for (int k = 0; k < order.size() && k < 5; k++) begin
      total++; if (order[k] != exp_order[k]) $display("FAIL rr_order[%0d]: got %0d expected %0d", k, order[k], exp_order[k]); else passed++;
      if (k > 0) begin
        total++; if (when[k] - when[k-1] != 2) $display("FAIL rr_interval[%0d]: got %0d expected 2", k, when[k] - when[k-1]); else passed++;
      end
    end
    total++; if (b4.m_araddr !== 32'h1000) $display("FAIL rr_last_addr: got %h expected 00001000", b4.m_araddr); else passed++;
  endtask

  task automatic test_stall();
    int pulses = 0;
    do_reset();
    b4.s_araddr[2*32 +: 32] = 32'h0000_3000;
    b4.s_arlen[2*8 +: 8] = 8'd7;
    b4.s_arvalid = 4'b0100;
    b4.m_arready = 1'b0;
    #1;
    total++; if (b4.s_arready !== 4'b0100) $display("FAIL stall_grant: got %b expected 0100", b4.s_arready); else passed++;
    pulses += int'(b4.s_arready[2]);
    tick();
    for (int c = 0; c < 5; c++) begin
      total++;
      if ({b4.m_arvalid, b4.m_araddr, b4.m_arid, b4.m_arlen} !== {1'b1, 32'h0000_3000, 2'd2, 8'd7})
        $display("FAIL stall_hold[%0d]: got %b/%h/%0d/%0d expected 1/00003000/2/7", c, b4.m_arvalid, b4.m_araddr, b4.m_arid, b4.m_arlen);
      else passed++;
      pulses += int'(b4.s_arready[2]);
      tick();
    end
    total++; if (pulses != 1) $display("FAIL stall_pulses: got %0d expected 1", pulses); else passed++;
    b4.m_arready = 1'b1;
    b4.s_arvalid = 4'b0000;
    tick();
    total++; if (b4.m_arvalid !== 1'b0) $display("FAIL stall_release: got %b expected 0", b4.m_arvalid); else passed++;
  endtask

  task automatic test_outst_limit();
    int grants = 0;
    int exp_grants = LIMIT ? 2 : 4;
    do_reset();
    b4.s_arvalid = 4'b0010;
    b4.m_arready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      total++; if (b4.s_arready !== exp_arready()) $display("FAIL outst_arready[%0d]: got %b expected %b", c, b4.s_arready, exp_arready()); else passed++;
      tick();
      if (tick_grant == 1) grants++;
    end
    total++; if (grants != exp_grants) $display("FAIL outst_grants: got %0d expected %0d", grants, exp_grants); else passed++;
    b4.s_arvalid = 4'b0000;
    b4.m_rvalid = 1'b1; b4.m_rid = 2'd1; b4.m_rlast = 1'b1; b4.s_rready = 4'b0010;
    #1;
    total++; if ({b4.m_rready, b4.s_rvalid} !== {1'b1, 4'b0010}) $display("FAIL outst_rbeat: got %b/%b expected 1/0010", b4.m_rready, b4.s_rvalid); else passed++;
    tick();
    b4.m_rvalid = 1'b0; b4.m_rlast = 1'b0;
    b4.s_arvalid = 4'b0010;
    #1;
    total++; if (b4.s_arready !== 4'b0010) $display("FAIL outst_regrant: got %b expected 0010", b4.s_arready); else passed++;
    tick();
  endtask

  task automatic test_r_route();
    logic [31:0] d;
    do_reset();
    b4.s_arlen[3*8 +: 8] = 8'd3;
    b4.s_araddr[3*32 +: 32] = 32'h4000;
    b4.s_arvalid = 4'b1000;
    b4.m_arready = 1'b1;
    tick();
    b4.s_arvalid = 4'b0000;
    total++; if ({b4.m_arid, b4.m_arlen} !== {2'd3, 8'd3}) $display("FAIL route_ar: got %0d/%0d expected 3/3", b4.m_arid, b4.m_arlen); else passed++;
    tick();
    b4.s_rready = 4'hF; b4.m_rvalid = 1'b1; b4.m_rid = 2'd3;
    for (int b = 0; b < 4; b++) begin
      d = $urandom;
      b4.m_rdata = d;
      b4.m_rlast = (b == 3);
      b4.m_rresp = axi_resp_t'(2'(b));
      #1;
      total++;
      if ({b4.s_rvalid, b4.m_rready, b4.s_rdata, b4.s_rresp, b4.s_rlast} !== {4'b1000, 1'b1, d, 2'(b), (b == 3)})
        $display("FAIL route_beat[%0d]: got %b/%b/%h/%0d/%b expected 1000/1/%h/%0d/%b", b, b4.s_rvalid, b4.m_rready, b4.s_rdata, b4.s_rresp, b4.s_rlast, d, b, (b == 3));
      else passed++;
      tick();
    end
    b4.m_rlast = 1'b0;
    b4.s_rready = 4'b0111;
    #1;
    total++; if ({b4.s_rvalid, b4.m_rready} !== {4'b1000, 1'b0}) $display("FAIL route_stall: got %b/%b expected 1000/0", b4.s_rvalid, b4.m_rready); else passed++;
    b4.m_rvalid = 1'b0;
    #1;
    total++; if (b4.s_rvalid !== 4'b0000) $display("FAIL route_idle: got %b expected 0000", b4.s_rvalid); else passed++;
    tick();
  endtask

  task automatic test_rid_err();
    do_reset();
    b3.m_rvalid = 1'b1; b3.m_rid = 2'd1; b3.s_rready = 3'b010;
    #1;
    total++; if ({b3.s_rvalid, b3.m_rready, rid_err3} !== {3'b010, 1'b1, 1'b0}) $display("FAIL riderr_valid_rid: got %b/%b/%b expected 010/1/0", b3.s_rvalid, b3.m_rready, rid_err3); else passed++;
    b3.m_rid = 2'd3; b3.s_rready = 3'b000; b3.m_rlast = 1'b1;
    #1;
    total++; if ({b3.m_rready, b3.s_rvalid} !== {1'b1, 3'b000}) $display("FAIL riderr_drain: got %b/%b expected 1/000", b3.m_rready, b3.s_rvalid); else passed++;
    tick();
    b3.m_rvalid = 1'b0;
    #1;
    total++; if (rid_err3 !== 1'b1) $display("FAIL riderr_set: got %b expected 1", rid_err3); else passed++;
    tick(); tick(); tick();
    total++; if (rid_err3 !== 1'b1) $display("FAIL riderr_sticky: got %b expected 1", rid_err3); else passed++;
    total++; if (rid_err4 !== 1'b0) $display("FAIL riderr_other: got %b expected 0", rid_err4); else passed++;
    do_reset();
    #1;
    total++; if (rid_err3 !== 1'b0) $display("FAIL riderr_clear: got %b expected 0", rid_err3); else passed++;
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    b4.s_arvalid = 4'b0100;
    b4.m_arready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    b4.s_arvalid = 4'b0101;
    b4.m_arready = 1'b0;
    #1;
    total++; if (b4.s_arready !== 4'b0001) $display("FAIL midrst_pre: got %b expected 0001", b4.s_arready); else passed++;
    tick();
    reset = 1'b1;
    tick();
    total++; if (b4.m_arvalid !== 1'b0) $display("FAIL midrst_arvalid: got %b expected 0", b4.m_arvalid); else passed++;
    reset = 1'b0;
    #1;
    total++; if (b4.s_arready !== 4'b0001) $display("FAIL midrst_first: got %b expected 0001", b4.s_arready); else passed++;
    b4.m_arready = 1'b1;
    tick(); tick();
    b4.s_arvalid = 4'b0100;
    #1;
    total++; if (b4.s_arready !== 4'b0100) $display("FAIL midrst_outst_clear: got %b expected 0100", b4.s_arready); else passed++;
    tick();
  endtask

  task automatic test_random();
    logic [52:0] got, exp;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      b4.s_arvalid = 4'($urandom);
      b4.s_araddr = {$urandom, $urandom, $urandom, $urandom};
      b4.s_arlen = $urandom;
      b4.m_arready = ($urandom_range(0, 3) != 0);
      b4.m_rvalid = 1'($urandom);
      b4.m_rid = 2'($urandom_range(0, 3));
      b4.m_rlast = 1'($urandom);
      b4.s_rready = 4'($urandom);
      b4.m_rdata = $urandom;
      #1;
      exp = {exp_arready(), mdl_busy, 2'(mdl_id), mdl_addr, mdl_len, exp_rvalid(), exp_rready(), mdl_err};
      got = {b4.s_arready, b4.m_arvalid, b4.m_arid, b4.m_araddr, b4.m_arlen, b4.s_rvalid, b4.m_rready, rid_err4};
      total++; if (got !== exp) $display("FAIL random[%0d]: got %h expected %h", c, got, exp); else passed++;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_rr_order();
    test_stall();
    test_outst_limit();
    test_r_route();
    test_rid_err();
    test_reset_mid_issue();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
